// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: single-outstanding instruction fetcher feeding a prefetch FIFO towards decode
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
    state_t state;
    logic [31:0] fetch_pc, rpc, head_pc, head_data;
    logic [31:0] mem_pc [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0] count, count_nxt;
    logic ack, push, pop, credit, bypass;
    assign rpc       = {redirect_pc[31:2], 2'b00};
    assign ack       = imem_req & imem_ack;
    assign push      = ack & (state == REQ) & !redirect_valid;
    assign pop       = inst_valid & inst_ready & !redirect_valid;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    assign credit    = count_nxt < (AW+1)'(DEPTH);
    assign rd_nxt    = rd_ptr + AW'(pop);
    assign bypass    = push & (wr_ptr == rd_nxt);
    assign head_pc   = bypass ? imem_addr : mem_pc[rd_nxt];
    assign head_data = bypass ? imem_rdata : mem_data[rd_nxt];
    // fetch control: issue, hold until ack, back-to-back refetch, and discard of the in-flight word on redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            imem_addr <= 32'h0;
            fetch_pc <= RESET_PC;
        end else begin
            if (redirect_valid)
                fetch_pc <= rpc;
            case (state)
                IDLE: if (!redirect_valid && credit) begin
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                    state     <= REQ;
                end
                REQ: if (redirect_valid && ack) begin
                    imem_addr <= rpc;
                end else if (redirect_valid) begin
                    state <= FLUSH;
                end else if (ack) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    if (credit) begin
                        imem_addr <= fetch_pc + 32'd4;
                    end else begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                FLUSH: if (ack) begin
                    imem_addr <= redirect_valid ? rpc : fetch_pc;
                    state     <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // FIFO storage; pushes never target a full FIFO thanks to the credit check
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= imem_addr;
            mem_data[wr_ptr] <= imem_rdata;
        end
    end
    // FIFO pointers, occupancy and registered head; redirect empties the queue and cancels the pop
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inst_valid <= 1'b0;
            if (rst) begin
                inst_data <= 32'h0;
                inst_pc   <= 32'h0;
            end
        end else begin
            count      <= count_nxt;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_nxt;
            inst_valid <= count_nxt != '0;
            if (count_nxt != '0) begin
                inst_pc   <= head_pc;
                inst_data <= head_data;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenarios with a PC/data scoreboard on the decode side
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, imem_ack, inst_valid, inst_ready = 1'b0, ack_en = 1'b0;
    logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
    logic [31:0] sb [$];
    int checks = 0, errors = 0, ack_cnt = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = data_of(imem_addr);

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // decode-side monitor: every accepted word must be the next scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ack)
                ack_cnt++;
            if (inst_valid && inst_ready && !redirect_valid) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word: observed pc %h expected none", inst_pc);
                end
                if (sb.size() != 0) begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst_data", inst_data, data_of(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        ack_en = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        sb.delete();
        ack_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int lim);
        for (int n = 0; n < lim && sb.size() != 0; n++)
            step();
        chk({tag, "_drained"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        // 1: streaming at one word per cycle
        do_reset();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        ack_en = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            sb.push_back(32'(4 * i));
        for (int k = 1; k <= 12 && sb.size() != 0; k++) begin
            step();
            if (k <= 9)
                chk("t1_addr", imem_addr, 32'(4 * (k - 1)));
            if (k >= 2 && sb.size() != 0)
                chk("t1_gapless", {31'h0, inst_valid}, 32'h1);
        end
        chk("t1_drained", 32'(sb.size()), 32'h0);
        inst_ready = 1'b0;

        // 2: back-pressure fills exactly DEPTH entries, then fetch resumes at 0x10
        do_reset();
        ack_en = 1'b1;
        repeat (10) step();
        chk("t2_acks", 32'(ack_cnt), 32'd4);
        chk("t2_req_off", {31'h0, imem_req}, 32'h0);
        chk("t2_valid", {31'h0, inst_valid}, 32'h1);
        chk("t2_head", inst_pc, 32'h0);
        for (int i = 0; i < 5; i++)
            sb.push_back(32'(4 * i));
        inst_ready = 1'b1;
        drain("t2", 30);
        inst_ready = 1'b0;

        // 3: redirect while idle with a full queue
        do_reset();
        ack_en = 1'b1;
        repeat (8) step();
        chk("t3_idle", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("t3_flushed", {31'h0, inst_valid}, 32'h0);
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        inst_ready = 1'b1;
        step();
        chk("t3_addr", imem_addr, 32'h40);
        chk("t3_req", {31'h0, imem_req}, 32'h1);
        drain("t3", 20);
        inst_ready = 1'b0;

        // 4: redirect with request 0x8 outstanding, ack two cycles later
        do_reset();
        ack_en = 1'b1;
        inst_ready = 1'b1;
        sb.push_back(32'h0);
        for (int n = 0; n < 10 && imem_addr !== 32'h8; n++)
            step();
        chk("t4_at8", imem_addr, 32'h8);
        ack_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk("t4_hold0", imem_addr, 32'h8);
        chk("t4_req", {31'h0, imem_req}, 32'h1);
        chk("t4_flushed", {31'h0, inst_valid}, 32'h0);
        step();
        chk("t4_hold1", imem_addr, 32'h8);
        ack_en = 1'b1;
        step();
        chk("t4_new", imem_addr, 32'h20);
        sb.push_back(32'h20);
        sb.push_back(32'h24);
        drain("t4", 20);
        inst_ready = 1'b0;

        // 5: redirect coinciding with ack and pop, unaligned target
        do_reset();
        ack_en = 1'b1;
        inst_ready = 1'b1;
        sb.push_back(32'h0);
        for (int n = 0; n < 10 && imem_addr !== 32'h8; n++)
            step();
        chk("t5_at8", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h23;
        step();
        redirect_valid = 1'b0;
        chk("t5_addr", imem_addr, 32'h20);
        chk("t5_req", {31'h0, imem_req}, 32'h1);
        chk("t5_flushed", {31'h0, inst_valid}, 32'h0);
        sb.push_back(32'h20);
        sb.push_back(32'h24);
        drain("t5", 20);
        inst_ready = 1'b0;

        // 6: address wrap, then reset in the middle of a request
        do_reset();
        ack_en = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        sb.push_back(32'hFFFF_FFF8);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0);
        step();
        chk("t6_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        chk("t6_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t6_addr2", imem_addr, 32'h0);
        drain("t6", 20);
        chk("t6_busy", {31'h0, imem_req}, 32'h1);
        rst = 1'b1;
        step();
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t6_rst_data", inst_data, 32'h0);
        chk("t6_rst_pc", inst_pc, 32'h0);
        inst_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
